// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner: tear-free load-latched value, hex/dash font,
// per-digit decimal points, leading-zero blanking and PWM brightness on the anodes.
module seg_scan_display #(
   parameter int DIGITS     = 4,
   parameter int DIV        = 50000,
   parameter int BRIGHT_W   = 4,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  hex_mode,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   // Internal logic works in active-low codes; these masks flip the pins when ACTIVE_LOW = 0.
   localparam logic [6:0]        SEG_INV = ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic              DP_INV  = ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic [DIGITS-1:0] AN_INV  = ACTIVE_LOW ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

   function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
      logic [6:0] dash;
      dash = 7'b0111111;
      case (nib)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = hex ? 7'b0001000 : dash;
         4'hB: decode = hex ? 7'b0000011 : dash;
         4'hC: decode = hex ? 7'b1000110 : dash;
         4'hD: decode = hex ? 7'b0100001 : dash;
         4'hE: decode = hex ? 7'b0000110 : dash;
         default: decode = hex ? 7'b0001110 : dash;
      endcase
   endfunction

   logic [PC_W-1:0]     pc_q, pc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                pend_flag_q, pend_flag_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_q, frame_d;

   logic                tick, boundary, upper_zero, blank, dp_bit, en;
   logic [3:0]          nib;
   logic [6:0]          seg_low;
   logic [DIGITS-1:0]   an_low;

   always_comb begin
      tick     = (pc_q == PC_W'(DIV - 1));
      boundary = tick && (idx_q == IDX_W'(DIGITS - 1));

      pc_d  = tick ? '0 : pc_q + 1'b1;
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

      // A load on the boundary wins; the transfer then waits one more frame.
      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      pend_val_d  = pend_val_q;
      pend_dp_d   = pend_dp_q;
      pend_flag_d = pend_flag_q;
      if (load) begin
         pend_val_d  = value;
         pend_dp_d   = dp_in;
         pend_flag_d = 1'b1;
      end else if (boundary && pend_flag_q) begin
         act_val_d   = pend_val_q;
         act_dp_d    = pend_dp_q;
         pend_flag_d = 1'b0;
      end

      upper_zero = 1'b1;
      blank      = 1'b0;
      nib        = 4'd0;
      dp_bit     = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (act_val_q[4*i +: 4] == 4'd0);
         if (idx_q == IDX_W'(i)) begin
            nib    = act_val_q[4*i +: 4];
            dp_bit = act_dp_q[i];
            blank  = blank_lz && (i != 0) && upper_zero;
         end
      end
      seg_low = blank ? 7'h7F : decode(nib, hex_mode);

      en     = (&brightness) || (pc_q[BRIGHT_W-1:0] < brightness);
      an_low = {DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         if (en && (idx_q == IDX_W'(i))) an_low[i] = 1'b0;
      end

      seg_d   = seg_low ^ SEG_INV;
      dp_d    = ~dp_bit ^ DP_INV;
      an_d    = an_low ^ AN_INV;
      frame_d = boundary;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q        <= '0;
         idx_q       <= '0;
         act_val_q   <= '0;
         act_dp_q    <= '0;
         pend_val_q  <= '0;
         pend_dp_q   <= '0;
         pend_flag_q <= 1'b0;
         seg_q       <= 7'h7F ^ SEG_INV;
         dp_q        <= 1'b1 ^ DP_INV;
         an_q        <= {DIGITS{1'b1}} ^ AN_INV;
         frame_q     <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         idx_q       <= idx_d;
         act_val_q   <= act_val_d;
         act_dp_q    <= act_dp_d;
         pend_val_q  <= pend_val_d;
         pend_dp_q   <= pend_dp_d;
         pend_flag_q <= pend_flag_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
         frame_q     <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign dp    = dp_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule
